fetch_queue_stage: RTL and testbench

- Parametrised next-generation instruction fetch stage for the 5-stage CPU.
- Owns the PC register and issues one instruction-SRAM read per cycle.
- Captures each response (1-cycle SRAM latency) into a DEPTH-entry {pc, inst} queue.
- Presents the queue head to decode with a valid/ready handshake.
- Handles exception, eret and branch redirect by flushing the queue and the in-flight response.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_queue_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_queue_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and queue entry type for the fetch stage.
// Optional macro FETCH_ADEL_CHECK_EN adds an address-error bit to each entry.
package fetch_pkg;

  localparam int unsigned FETCH_AW           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc0_0380;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [31:0]         inst;
`ifdef FETCH_ADEL_CHECK_EN
    logic                adel;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear, occupancy count and a head read from storage registers.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1),
  parameter type         entry_t = logic [31:0]
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_push,
  input  entry_t        i_data,
  input  logic          i_pop,
  output entry_t        o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  entry_t            r_mem [DEPTH];
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      // Clear wins over any same-cycle push or pop.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_push && !i_clear) begin
      assert (!o_full);
    end
  end
`endif

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: PC register, one SRAM read per cycle, response queue towards decode.
// Optional macro FETCH_ADEL_CHECK_EN: misaligned PCs produce an address-error entry instead of a read.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int unsigned   AW         = FETCH_AW,
  parameter logic [AW-1:0] RESET_PC   = AW'(RESET_PC_DEFAULT),
  parameter logic [AW-1:0] EXC_VECTOR = AW'(EXC_VECTOR_DEFAULT),
  parameter int unsigned   DEPTH      = 4,
  parameter int unsigned   CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  output logic          inst_sram_en,
  output logic [AW-1:0] inst_sram_addr,
  input  logic [31:0]   inst_sram_rdata,
  input  logic          exception,
  input  logic          eret,
  input  logic [AW-1:0] epc,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target,
  input  logic          de_ready,
  output logic          fe_valid,
  output logic [AW-1:0] fe_pc,
  output logic [31:0]   fe_inst,
  output logic          fe_adel,
  output logic [CW-1:0] fe_count
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_inflight_pc;
  logic          r_inflight;
  logic [AW-1:0] w_target;
  logic          w_flush;
  logic          w_slot;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occupancy;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  always_comb begin
    w_flush = exception | eret | br_valid;
    if (exception) begin
      w_target = EXC_VECTOR;
    end else if (eret) begin
      w_target = epc;
    end else begin
      w_target = br_target;
    end
  end

  // Reserve a slot for the in-flight response so a push can never hit a full queue.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_slot      = !w_full && (w_occupancy < (CW + 1)'(DEPTH));
  assign w_pop       = !w_empty && de_ready;

`ifdef FETCH_ADEL_CHECK_EN
  logic w_misaligned;
  logic w_adel_push;
  logic r_adel_done;

  assign w_misaligned = |r_pc[1:0];
  assign w_adel_push  = resetn && !w_flush && w_misaligned && !r_adel_done && !r_inflight && w_slot;
  assign w_issue      = resetn && !w_flush && w_slot && !w_misaligned;
  assign w_push       = (r_inflight && !w_flush) || w_adel_push;

  // One error entry per misaligned target; the PC then parks until a redirect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_adel_done <= 1'b0;
    end else if (w_flush) begin
      r_adel_done <= 1'b0;
    end else if (w_adel_push) begin
      r_adel_done <= 1'b1;
    end
  end

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.pc   = FETCH_AW'(r_inflight_pc);
    w_push_entry.inst = inst_sram_rdata;
    if (w_adel_push) begin
      w_push_entry.pc   = FETCH_AW'(r_pc);
      w_push_entry.inst = '0;
      w_push_entry.adel = 1'b1;
    end
  end

  assign fe_adel = w_head.adel;
`else
  assign w_issue = resetn && !w_flush && w_slot;
  assign w_push  = r_inflight && !w_flush;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.pc   = FETCH_AW'(r_inflight_pc);
    w_push_entry.inst = inst_sram_rdata;
  end

  assign fe_adel = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (w_flush) begin
      r_pc       <= w_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + AW'(4);
        r_inflight_pc <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .CW      (CW),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_clear (w_flush),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign inst_sram_en   = w_issue;
  assign inst_sram_addr = r_pc;
  assign fe_valid       = !w_empty;
  assign fe_pc          = AW'(w_head.pc);
  assign fe_inst        = w_head.inst;
  assign fe_count       = w_count;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: a spec-level reference model feeds a scoreboard of expected
// queue entries; directed phases cover start-up, back-pressure, redirect priority and flushes.
module tb_fetch_queue_stage;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'hbfc0_0000;
  localparam logic [31:0] EXC_PC = 32'hbfc0_0380;

  logic        clk;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        exception;
  logic        eret;
  logic [31:0] epc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        de_ready;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_inst;
  logic        fe_adel;
  logic [2:0]  fe_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic        m_inflight;
  logic [31:0] m_inflight_pc;
  logic        m_adel_done;

  fetch_queue_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .exception       (exception),
    .eret            (eret),
    .epc             (epc),
    .br_valid        (br_valid),
    .br_target       (br_target),
    .de_ready        (de_ready),
    .fe_valid        (fe_valid),
    .fe_pc           (fe_pc),
    .fe_inst         (fe_inst),
    .fe_adel         (fe_adel),
    .fe_count        (fe_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // Instruction SRAM: one-cycle read latency, garbage when no request was made.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= sram_word(inst_sram_addr);
    else              inst_sram_rdata <= 32'hdead_beef;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else             n_pass++;
  endtask

  // Reference model: compare this cycle's outputs, then advance to the post-edge state.
  always @(negedge clk) begin : model
    logic        flush, en, pop, mis, adel_push;
    logic [31:0] tgt;
    if (!resetn) begin
      sb.delete();
      m_pc = RST_PC; m_inflight = 1'b0; m_inflight_pc = '0; m_adel_done = 1'b0;
      check("rst_en", {31'b0, inst_sram_en}, 32'd0);
      check("rst_valid", {31'b0, fe_valid}, 32'd0);
      check("rst_count", {29'b0, fe_count}, 32'd0);
      check("rst_pc", fe_pc, 32'd0);
      check("rst_inst", fe_inst, 32'd0);
      check("rst_adel", {31'b0, fe_adel}, 32'd0);
    end else begin
      flush = exception | eret | br_valid;
      tgt   = exception ? EXC_PC : (eret ? epc : br_target);
`ifdef FETCH_ADEL_CHECK_EN
      mis = (m_pc[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      en        = !flush && !mis && (sb.size() + int'(m_inflight) < DEPTH);
      adel_push = !flush && mis && !m_adel_done && !m_inflight
                  && (sb.size() + int'(m_inflight) < DEPTH);
      pop       = (sb.size() != 0) && de_ready;
      check("sram_en", {31'b0, inst_sram_en}, {31'b0, en});
      if (en) check("sram_addr", inst_sram_addr, m_pc);
      check("count", {29'b0, fe_count}, sb.size());
      check("valid", {31'b0, fe_valid}, {31'b0, sb.size() != 0});
      if (sb.size() != 0) begin
        check("head_pc", fe_pc, sb[0].pc);
        check("head_inst", fe_inst, sb[0].inst);
        check("head_adel", {31'b0, fe_adel}, {31'b0, sb[0].adel});
      end
      if (flush) begin
        sb.delete();
        m_pc = tgt; m_inflight = 1'b0; m_adel_done = 1'b0;
      end else begin
        if (pop) void'(sb.pop_front());
        if (m_inflight) sb.push_back('{pc: m_inflight_pc, inst: sram_word(m_inflight_pc), adel: 1'b0});
        if (adel_push) begin
          sb.push_back('{pc: m_pc, inst: 32'd0, adel: 1'b1});
          m_adel_done = 1'b1;
        end
        m_inflight = en;
        if (en) begin
          m_inflight_pc = m_pc;
          m_pc          = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic ready);
    resetn = 1'b0; de_ready = ready;
    tick(1);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; exception = 1'b0; eret = 1'b0; br_valid = 1'b0;
    epc = '0; br_target = '0; de_ready = 1'b1;
    tick(2);
    check("reset_en", {31'b0, inst_sram_en}, 32'd0);
    check("reset_count", {29'b0, fe_count}, 32'd0);

    // Start-up: request in the first cycle out of reset, first valid two cycles later.
    resetn = 1'b1; #1;
    check("boot_en0", {31'b0, inst_sram_en}, 32'd1);
    check("boot_addr0", inst_sram_addr, RST_PC);
    tick(1);
    check("boot_addr1", inst_sram_addr, RST_PC + 32'd4);
    check("boot_valid1", {31'b0, fe_valid}, 32'd0);
    tick(1);
    check("boot_valid2", {31'b0, fe_valid}, 32'd1);
    check("boot_pc2", fe_pc, RST_PC);
    tick(10);

    // Back-pressure: queue saturates, issue resumes the cycle after the first pop.
    restart(1'b0);
    tick(5);
    check("full_count", {29'b0, fe_count}, 32'd4);
    check("full_en", {31'b0, inst_sram_en}, 32'd0);
    check("full_head", fe_pc, RST_PC);
    de_ready = 1'b1;
    tick(1);
    check("resume_count", {29'b0, fe_count}, 32'd3);
    check("resume_en", {31'b0, inst_sram_en}, 32'd1);
    check("resume_addr", inst_sram_addr, RST_PC + 32'h10);
    check("resume_head", fe_pc, RST_PC + 32'd4);
    tick(8);

    // Exception with three entries queued and one response in flight.
    restart(1'b0);
    tick(4);
    check("exc_pre_count", {29'b0, fe_count}, 32'd3);
    exception = 1'b1; #1;
    check("exc_en", {31'b0, inst_sram_en}, 32'd0);
    tick(1);
    exception = 1'b0; #1;
    check("exc_count", {29'b0, fe_count}, 32'd0);
    check("exc_addr", inst_sram_addr, EXC_PC);
    de_ready = 1'b1;
    tick(2);
    check("exc_valid", {31'b0, fe_valid}, 32'd1);
    check("exc_head", fe_pc, EXC_PC);

    // Redirect priority: eret over branch, exception over eret.
    epc = 32'h8000_1000; br_target = 32'h8000_2000; eret = 1'b1; br_valid = 1'b1;
    tick(1);
    eret = 1'b0; br_valid = 1'b0; #1;
    check("eret_addr", inst_sram_addr, 32'h8000_1000);
    tick(3);
    exception = 1'b1; eret = 1'b1;
    tick(1);
    exception = 1'b0; eret = 1'b0; #1;
    check("exc_eret_addr", inst_sram_addr, EXC_PC);

    // Fill, then random back-pressure and aligned redirects.
    de_ready = 1'b0;
    tick(8);
    check("refill_count", {29'b0, fe_count}, 32'd4);
    for (int i = 0; i < 300; i++) begin
      int r;
      r         = $urandom_range(0, 24);
      de_ready  = ($urandom_range(0, 3) != 0);
      epc       = $urandom & 32'hffff_fffc;
      br_target = $urandom & 32'hffff_fffc;
      exception = (r == 0) || (r == 4);
      eret      = (r == 1) || (r == 3) || (r == 4);
      br_valid  = (r == 2) || (r == 3) || (r == 4);
      tick(1);
    end
    exception = 1'b0; eret = 1'b0; br_valid = 1'b0; de_ready = 1'b1;
    tick(10);

`ifdef FETCH_ADEL_CHECK_EN
    de_ready = 1'b0; br_target = 32'h8000_0002; br_valid = 1'b1;
    tick(1);
    br_valid = 1'b0; #1;
    check("adel_en", {31'b0, inst_sram_en}, 32'd0);
    tick(1);
    check("adel_valid", {31'b0, fe_valid}, 32'd1);
    check("adel_pc", fe_pc, 32'h8000_0002);
    check("adel_inst", fe_inst, 32'd0);
    check("adel_flag", {31'b0, fe_adel}, 32'd1);
    de_ready = 1'b1;
    tick(3);
    check("adel_stall_en", {31'b0, inst_sram_en}, 32'd0);
    check("adel_stall_count", {29'b0, fe_count}, 32'd0);
    exception = 1'b1;
    tick(1);
    exception = 1'b0; #1;
    check("adel_exit_addr", inst_sram_addr, EXC_PC);
    tick(5);
`endif

    // Reset mid-stream: the outstanding response must not appear.
    de_ready = 1'b0;
    tick(1);
    resetn = 1'b0; #1;
    check("midrst_count", {29'b0, fe_count}, 32'd0);
    tick(1);
    resetn = 1'b1;
    tick(3);
    check("midrst_head", fe_pc, RST_PC);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
